deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Upstream companion of the 256-to-64 output serializer.
- Accepts a stream of INWIDTH-bit words over a valid/ready handshake and packs them into one OUTWIDTH-bit block. The first received word goes to the least-significant slice, which matches the serializer's LSB-first emission order.
- Presents each completed block on a valid/ready output. It holds the block until the consumer takes it.
- An early-terminate input (in_last) closes a partial block, zero-padded, so short final messages can be handed to the Haraka-S core.

Parameters:
- INWIDTH, 64, width of each input word.
- OUTWIDTH, 256, width of the assembled block; must be an integer multiple of INWIDTH, with ratio 2 or more.
- WORDS, OUTWIDTH/INWIDTH (derived, localparam), number of words per block.
- CW, $clog2(WORDS)+1 (derived, localparam), width of word-count signals.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  INWIDTH  input word.
- in_valid  input  1  in_data is valid.
- in_last  input  1  this word is the final word of the current block; qualified by in_valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  OUTWIDTH  assembled block.
- out_valid  output  1  out_data holds a complete block.
- out_ready  input  1  consumer accepts the block.
- out_words  output  CW  number of real words in out_data (1..WORDS).

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately and overrides a block mid-fill or mid-hold):
  - state=COLLECT, word count=0, shift buffer=0.
  - out_data=0, out_valid=0, out_words=0.
  - in_ready=1 once rst deasserts.
- Transfer rules:
  - Input transfer when in_valid & in_ready at the rising edge of clk.
  - Output transfer when out_valid & out_ready.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Each input transfer writes in_data into slice [cnt*INWIDTH +: INWIDTH] and increments cnt.
  - Block completes when the transfer is either the WORDS-th word, or has in_last=1.
  - On completion:
    - out_data <= buffer with the new word merged in; slices at index >= cnt+1 are forced to 0.
    - out_words <= cnt+1.
    - Go to HOLD with out_valid=1 on the next cycle.
    - Clear the buffer and cnt to 0.
  - Latency: out_valid rises one cycle after the completing input transfer.
- State HOLD:
  - out_valid=1; out_data and out_words stay stable until an output transfer.
  - in_ready = out_ready (combinational pass-through).
  - Output transfer with no input transfer: go to COLLECT, out_valid=0.
  - Output and input transfer in the same cycle: the new word is written to slice 0 and cnt=1.
    - If that word has in_last=1, or WORDS==1 is impossible by parameter rule, so only in_last applies: out_data is reloaded with the 1-word block, out_words=1, and the block stays in HOLD with out_valid=1 (back-to-back).
    - Otherwise go to COLLECT.
  - Result: sustained throughput of one word per cycle with no bubble.
- Boundary conditions:
  - in_last on the WORDS-th word: same as a normal full block, out_words=WORDS.
  - in_last while cnt=0 (first word): 1-word block, upper slices 0.
  - in_valid=0: no state change; in_last is ignored unless in_valid=1.
  - out_ready asserted while out_valid=0: no effect.
  - cnt never exceeds WORDS-1 in COLLECT; there is no overflow path.
- All registers are clocked on the rising edge of clk only; there are no other clock domains.

Test Plan:
- Four back-to-back words 0x11..11, 0x22..22, 0x33..33, 0x44..44 with out_ready=1 -> one cycle after the fourth word: out_valid=1, out_data = {0x44..44, 0x33..33, 0x22..22, 0x11..11}, out_words=4; in_ready never drops.
- Two words 0xA..A, 0xB..B, with in_last on the second -> out_data = {0, 0, 0xB..B, 0xA..A}, out_words=2.
- Full block completes while out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout; out_data is stable. When out_ready rises, the pending word transfers in that same cycle as word 0 of the next block.
- Continuous 12-word stream with out_ready=1 -> three blocks, each out_valid pulse lasts 1 cycle, no input stall, word order correct in every block.
- rst pulsed after 2 of 4 words, then 4 new words -> after reset out_valid=0 and out_data=0; the next block contains only the 4 post-reset words, and out_words=4.
- Single word with in_last while the previous block is being consumed in the same cycle -> the block stays in HOLD, out_words=1, out_data upper 192 bits are 0.

Source files
------------

// File: rtl/deserializer.sv
// Packs a stream of INWIDTH-bit words (first word into the LSB slice) into OUTWIDTH-bit blocks.
// Latency: out_valid rises one cycle after the word that completes a block; the output holds one block.
// Backpressure: while a block is held, in_ready follows out_ready, so a stalled consumer stalls the producer.
module deserializer #(
  parameter  int INWIDTH  = 64,
  parameter  int OUTWIDTH = 256,
  localparam int WORDS    = OUTWIDTH / INWIDTH,
  localparam int CW       = $clog2(WORDS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INWIDTH-1:0]  in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [OUTWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_words
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [OUTWIDTH-1:0] shift_buf, shift_buf_n;
  logic [OUTWIDTH-1:0] out_data_n;
  logic [CW-1:0]       out_words_n;
  logic [OUTWIDTH-1:0] merged;

  // Current partial block with the incoming word in slice cnt and every slice above it zeroed.
  always_comb begin
    merged = shift_buf;
    for (int i = 0; i < WORDS; i++) begin
      if (CW'(i) == cnt) begin
        merged[i*INWIDTH +: INWIDTH] = in_data;
      end else if (CW'(i) > cnt) begin
        merged[i*INWIDTH +: INWIDTH] = '0;
      end
    end
  end

  // State register; reset drops any block being filled or held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shift_buf_n = shift_buf;
    out_data_n  = out_data;
    out_words_n = out_words;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last || cnt == CW'(WORDS - 1)) begin
            out_data_n  = merged;
            out_words_n = cnt + CW'(1);
            shift_buf_n = '0;
            cnt_n       = '0;
            state_n     = HOLD;
          end else begin
            shift_buf_n = merged;
            cnt_n       = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // Accept a word only in the cycle the held block leaves, so no bubble appears.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            if (in_last) begin
              // Single-word block replaces the departing one and is held straight away.
              out_data_n  = OUTWIDTH'(in_data);
              out_words_n = CW'(1);
            end else begin
              shift_buf_n = OUTWIDTH'(in_data);
              cnt_n       = CW'(1);
              state_n     = COLLECT;
            end
          end else begin
            state_n = COLLECT;
          end
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // Datapath registers: partial-block buffer, word count and the presented block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      shift_buf <= '0;
      out_data  <= '0;
      out_words <= '0;
    end else begin
      cnt       <= cnt_n;
      shift_buf <= shift_buf_n;
      out_data  <= out_data_n;
      out_words <= out_words_n;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed, table-driven bench for the deserializer: one row per clock cycle,
// giving the inputs for that cycle and the outputs expected before its rising edge.
module tb_deserializer;

  localparam int IW = 64;
  localparam int OW = 256;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_words;

  deserializer #(.INWIDTH(IW), .OUTWIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_words(out_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          vld;
    logic          last;
    logic          ordy;
    logic [IW-1:0] din;
    logic          e_rdy;
    logic          e_ov;
    logic          chk;     // compare out_data/out_words in this row
    logic [OW-1:0] e_od;
    logic [CW-1:0] e_ow;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   passed;

  function automatic logic [IW-1:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  function automatic logic [OW-1:0] blk(input logic [7:0] w0, w1, w2, w3);
    logic [OW-1:0] r;
    r = {(w3 == 8'h00) ? 64'h0 : rep(w3), (w2 == 8'h00) ? 64'h0 : rep(w2),
         (w1 == 8'h00) ? 64'h0 : rep(w1), rep(w0)};
    return r;
  endfunction

  function automatic void add(input logic r, v, l, o, input logic [7:0] d,
                              input logic e_rdy, e_ov, chk,
                              input logic [OW-1:0] e_od, input logic [CW-1:0] e_ow);
    vec_t x;
    x.rst = r; x.vld = v; x.last = l; x.ordy = o; x.din = rep(d);
    x.e_rdy = e_rdy; x.e_ov = e_ov; x.chk = chk; x.e_od = e_od; x.e_ow = e_ow;
    vq.push_back(x);
  endfunction

  task automatic check(input string nm, input int row, input logic [OW-1:0] got, exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s row %0d: got %h want %h", nm, row, got, exp);
  endtask

  initial begin
    vec_t v;
    logic [7:0] b;
    total = 0; passed = 0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;

    // reset state
    add(1,0,0,0,8'h00, 1,0,1, '0, 0);
    add(1,0,0,1,8'h00, 1,0,1, '0, 0);
    add(0,0,0,0,8'h00, 1,0,1, '0, 0);

    // four back-to-back words, out_ready high, in_ready never drops
    add(0,1,0,1,8'h11, 1,0,0, '0, 0);
    add(0,1,0,1,8'h22, 1,0,0, '0, 0);
    add(0,1,0,1,8'h33, 1,0,0, '0, 0);
    add(0,1,0,1,8'h44, 1,0,0, '0, 0);
    add(0,0,0,1,8'h00, 1,1,1, blk(8'h11,8'h22,8'h33,8'h44), 4);

    // two words, in_last on the second, consumer initially stalled
    add(0,1,0,1,8'hAA, 1,0,0, '0, 0);
    add(0,1,1,1,8'hBB, 1,0,0, '0, 0);
    add(0,0,0,0,8'h00, 0,1,1, blk(8'hAA,8'hBB,8'h00,8'h00), 2);
    add(0,0,0,1,8'h00, 1,1,1, blk(8'hAA,8'hBB,8'h00,8'h00), 2);

    // full block then 5 stalled cycles with a pending word; it enters as word 0
    add(0,1,0,0,8'h01, 1,0,0, '0, 0);
    add(0,1,0,0,8'h02, 1,0,0, '0, 0);
    add(0,1,0,0,8'h03, 1,0,0, '0, 0);
    add(0,1,0,0,8'h04, 1,0,0, '0, 0);
    for (int k = 0; k < 5; k++) add(0,1,0,0,8'h05, 0,1,1, blk(8'h01,8'h02,8'h03,8'h04), 4);
    add(0,1,0,1,8'h05, 1,1,1, blk(8'h01,8'h02,8'h03,8'h04), 4);
    add(0,1,0,1,8'h06, 1,0,0, '0, 0);
    add(0,1,0,1,8'h07, 1,0,0, '0, 0);
    add(0,1,0,1,8'h08, 1,0,0, '0, 0);
    add(0,0,0,1,8'h00, 1,1,1, blk(8'h05,8'h06,8'h07,8'h08), 4);

    // continuous 12-word stream: three blocks, 1-cycle out_valid pulses, no stall
    for (int k = 0; k < 12; k++) begin
      b = 8'h60 + 8'(k);
      if (k >= 4 && k % 4 == 0)
        add(0,1,0,1,b, 1,1,1, blk(b-8'd4,b-8'd3,b-8'd2,b-8'd1), 4);
      else
        add(0,1,0,1,b, 1,0,0, '0, 0);
    end
    add(0,0,0,1,8'h00, 1,1,1, blk(8'h68,8'h69,8'h6A,8'h6B), 4);
    add(0,0,0,1,8'h00, 1,0,0, '0, 0);

    // reset after 2 of 4 words, then a clean 4-word block
    add(0,1,0,1,8'hC1, 1,0,0, '0, 0);
    add(0,1,0,1,8'hC2, 1,0,0, '0, 0);
    add(1,0,0,1,8'h00, 1,0,1, '0, 0);
    add(0,0,0,1,8'h00, 1,0,1, '0, 0);
    add(0,1,0,1,8'hD1, 1,0,0, '0, 0);
    add(0,1,0,1,8'hD2, 1,0,0, '0, 0);
    add(0,1,0,1,8'hD3, 1,0,0, '0, 0);
    add(0,1,0,1,8'hD4, 1,0,0, '0, 0);
    add(0,0,0,1,8'h00, 1,1,1, blk(8'hD1,8'hD2,8'hD3,8'hD4), 4);

    // in_last on the first word from COLLECT
    add(0,1,1,1,8'h99, 1,0,0, '0, 0);
    add(0,0,0,1,8'h00, 1,1,1, blk(8'h99,8'h00,8'h00,8'h00), 1);

    // in_last ignored without in_valid; in_last on the 4th word gives a full block
    add(0,1,0,1,8'h31, 1,0,0, '0, 0);
    add(0,1,0,1,8'h32, 1,0,0, '0, 0);
    add(0,0,1,1,8'h7F, 1,0,0, '0, 0);
    add(0,1,0,1,8'h33, 1,0,0, '0, 0);
    add(0,1,1,1,8'h34, 1,0,0, '0, 0);
    add(0,0,0,0,8'h00, 0,1,1, blk(8'h31,8'h32,8'h33,8'h34), 4);

    // single in_last word accepted while the held block is consumed: stays in HOLD
    add(0,1,1,1,8'hF1, 1,1,1, blk(8'h31,8'h32,8'h33,8'h34), 4);
    add(0,0,0,0,8'h00, 0,1,1, blk(8'hF1,8'h00,8'h00,8'h00), 1);
    add(0,0,0,1,8'h00, 1,1,1, blk(8'hF1,8'h00,8'h00,8'h00), 1);
    add(0,0,0,1,8'h00, 1,0,0, '0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rst = v.rst; in_valid = v.vld; in_last = v.last; out_ready = v.ordy; in_data = v.din;
      @(negedge clk);
      check("in_ready", i, OW'(in_ready), OW'(v.e_rdy));
      check("out_valid", i, OW'(out_valid), OW'(v.e_ov));
      if (v.chk) begin
        check("out_data", i, out_data, v.e_od);
        check("out_words", i, OW'(out_words), OW'(v.e_ow));
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
